// File: rtl/ads_dual_reader.sv
// Dual-channel serial ADC front end: periodic CONVST, then a 2x16-bit
// MSB-first shift from a simultaneous-sampling ADS converter.
module ads_dual_reader #(
    parameter int DATAWIDTH     = 16,
    parameter int SCLK_DIV      = 2,
    parameter int CONV_CYCLES   = 100,
    parameter int SAMPLE_PERIOD = 500,
    parameter int EN_HOLD       = 4
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 ads_convst,
    output logic                 ads_cs_n,
    output logic                 ads_sclk,
    input  logic                 ads_sdo_a,
    input  logic                 ads_sdo_b,
    output logic [DATAWIDTH-1:0] Ch0_Data,
    output logic [DATAWIDTH-1:0] Ch1_Data,
    output logic                 Ch0_Data_en,
    output logic                 Ch1_Data_en,
    output logic                 overrun
);

    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(DATAWIDTH + 1);
    localparam int EW = $clog2(EN_HOLD + 1);

    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATAWIDTH - 1);
    localparam logic [EW-1:0] E_LAST = EW'(EN_HOLD - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t state, nstate;

    logic [PW-1:0]        p;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        dcnt;
    logic                 half;
    logic [BW-1:0]        bcnt;
    logic [EW-1:0]        ecnt;
    logic                 en;
    logic [DATAWIDTH-1:0] sh_a, sh_b;

    logic p_zero, conv_end, bit_edge, shift_end;
    logic half_n, convst_d, cs_n_d, sclk_d, overrun_d;
    logic sample, load;

    assign p_zero    = (p == '0);
    assign conv_end  = (cnt == C_LAST);
    assign bit_edge  = (dcnt == D_LAST);
    assign shift_end = (bcnt == B_LAST) && half && bit_edge;

    always_ff @(posedge clk1) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:  if (p_zero && enable) nstate = CONV;
            CONV:  if (conv_end)         nstate = SHIFT;
            SHIFT: if (shift_end)        nstate = DONE;
            DONE:                        nstate = IDLE;
            default:                     nstate = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registers line up with it
    always_comb begin
        half_n    = (state == SHIFT) ? (half ^ bit_edge) : 1'b0;
        convst_d  = (state == IDLE) && (nstate == CONV);
        cs_n_d    = (nstate != SHIFT);
        sclk_d    = !((nstate == SHIFT) && !half_n);
        overrun_d = p_zero && (state != IDLE);
        sample    = (state == SHIFT) && !half && bit_edge;
        load      = (state == SHIFT) && (nstate == DONE);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            p          <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            half       <= 1'b0;
            bcnt       <= '0;
            ecnt       <= '0;
            en         <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            Ch0_Data   <= '0;
            Ch1_Data   <= '0;
            ads_convst <= 1'b0;
            ads_cs_n   <= 1'b1;
            ads_sclk   <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            p          <= (p == P_LAST) ? '0 : p + 1'b1;
            cnt        <= (state == CONV) ? cnt + 1'b1 : '0;
            ads_convst <= convst_d;
            ads_cs_n   <= cs_n_d;
            ads_sclk   <= sclk_d;
            overrun    <= overrun_d;

            if (state != SHIFT) begin
                dcnt <= '0;
                half <= 1'b0;
                bcnt <= '0;
            end else if (bit_edge) begin
                dcnt <= '0;
                half <= ~half;
                if (half) bcnt <= bcnt + 1'b1;
            end else begin
                dcnt <= dcnt + 1'b1;
            end

            // sdo sampled on the edge that ends the sclk low phase
            if (sample) begin
                sh_a <= {sh_a[DATAWIDTH-2:0], ads_sdo_a};
                sh_b <= {sh_b[DATAWIDTH-2:0], ads_sdo_b};
            end

            if (load) begin
                Ch0_Data <= sh_a;
                Ch1_Data <= sh_b;
                en       <= 1'b1;
                ecnt     <= E_LAST;
            end else if (ecnt != '0) begin
                ecnt <= ecnt - 1'b1;
            end else begin
                en <= 1'b0;
            end
        end
    end

    assign Ch0_Data_en = en;
    assign Ch1_Data_en = en;

endmodule
